// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide sequencer: operation codes and FSM states.
package mdu_pkg;

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_UMULL = 2'b01;
    localparam logic [1:0] OP_SMULL = 2'b10;
    localparam logic [1:0] OP_UDIV  = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_FIX   = 2'b10;
    localparam logic [1:0] ST_DONE  = 2'b11;

endpackage

// File: rtl/mdu_sequencer_if.sv
// Request/response bundle between execute (master) and the multiply/divide unit (slave).
interface mdu_sequencer_if #(
    parameter int WIDTH = 32
) ();

    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] result_lo;
    logic [WIDTH-1:0] result_hi;
    logic             div_by_zero;

    modport master (
        output start, op, a, b,
        input  busy, stall, done, result_lo, result_hi, div_by_zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, stall, done, result_lo, result_hi, div_by_zero
    );

endinterface

// File: rtl/mdu_core.sv
// Datapath for the sequencer: shift-add multiply, restoring divide and final negate.
// The divide step exists only when MDU_DIV_EN is defined.
module mdu_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step_mul,
    input  logic             step_div,
    input  logic             negate,
    input  logic [WIDTH-1:0] load_m,
    input  logic [WIDTH-1:0] load_lo,
    output logic [WIDTH-1:0] fin_hi,
    output logic [WIDTH-1:0] fin_lo
);

    logic [WIDTH-1:0]   m_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic [WIDTH:0]     sum_s;
    logic [2*WIDTH-1:0] neg_s;

    // Carry out of the add becomes the bit shifted into the top of the accumulator
    assign sum_s = {1'b0, hi_r} + (lo_r[0] ? {1'b0, m_r} : {(WIDTH+1){1'b0}});
    assign neg_s = ~{hi_r, lo_r} + (2*WIDTH)'(1);

`ifdef MDU_DIV_EN
    logic [WIDTH:0]   shl_s;
    logic [WIDTH+1:0] diff_s;
    logic             unused_diff_bit;

    assign shl_s           = {hi_r, lo_r[WIDTH-1]};
    assign diff_s          = {1'b0, shl_s} - {2'b00, m_r};
    assign unused_diff_bit = diff_s[WIDTH];
`else
    logic unused_step_div;

    assign unused_step_div = step_div;
`endif

    // Accumulator / remainder / multiplicand registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_r  <= '0;
            hi_r <= '0;
            lo_r <= '0;
        end else if (load) begin
            m_r  <= load_m;
            hi_r <= '0;
            lo_r <= load_lo;
        end else if (step_mul) begin
            hi_r <= sum_s[WIDTH:1];
            lo_r <= {sum_s[0], lo_r[WIDTH-1:1]};
`ifdef MDU_DIV_EN
        end else if (step_div) begin
            if (diff_s[WIDTH+1]) begin
                hi_r <= shl_s[WIDTH-1:0];
                lo_r <= {lo_r[WIDTH-2:0], 1'b0};
            end else begin
                hi_r <= diff_s[WIDTH-1:0];
                lo_r <= {lo_r[WIDTH-2:0], 1'b1};
            end
`endif
        end else if (negate) begin
            {hi_r, lo_r} <= neg_s;
        end else begin
            m_r  <= m_r;
            hi_r <= hi_r;
            lo_r <= lo_r;
        end
    end

    assign {fin_hi, fin_lo} = negate ? neg_s : {hi_r, lo_r};

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle multiply/divide sequencer: FSM, iteration counter, stall handshake, result regs.
// Define MDU_DIV_EN to include the restoring divider for UDIV.
module mdu_sequencer
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           reset,
    mdu_sequencer_if.slave bus
);

    localparam int CW = $clog2(WIDTH);

    logic [1:0]       state_r;
    logic [1:0]       state_s;
    logic [1:0]       op_r;
    logic             neg_r;
    logic [CW-1:0]    count_r;
    logic             busy_r;
    logic             done_r;
    logic             dbz_r;
    logic [WIDTH-1:0] res_lo_r;
    logic [WIDTH-1:0] res_hi_r;
    logic             accept_s;
    logic             short_s;
    logic             load_s;
    logic             step_mul_s;
    logic             step_div_s;
    logic             negate_s;
    logic [WIDTH-1:0] a_abs_s;
    logic [WIDTH-1:0] b_abs_s;
    logic [WIDTH-1:0] load_m_s;
    logic [WIDTH-1:0] load_lo_s;
    logic [WIDTH-1:0] fin_hi_s;
    logic [WIDTH-1:0] fin_lo_s;

    assign a_abs_s = bus.a[WIDTH-1] ? (~bus.a + WIDTH'(1)) : bus.a;
    assign b_abs_s = bus.b[WIDTH-1] ? (~bus.b + WIDTH'(1)) : bus.b;

    // UDIV that skips iteration: divisor zero, or no divider built at all
`ifdef MDU_DIV_EN
    assign short_s = (bus.op == OP_UDIV) && (bus.b == '0);
`else
    assign short_s = (bus.op == OP_UDIV);
`endif

    // Operand routing: SMULL iterates on magnitudes, divide puts the dividend in the low half
    always_comb begin
        load_m_s  = bus.a;
        load_lo_s = bus.b;
        case (bus.op)
            OP_MUL, OP_UMULL: begin
                load_m_s  = bus.a;
                load_lo_s = bus.b;
            end
            OP_SMULL: begin
                load_m_s  = a_abs_s;
                load_lo_s = b_abs_s;
            end
            OP_UDIV: begin
                load_m_s  = bus.b;
                load_lo_s = bus.a;
            end
            default: begin
                load_m_s  = bus.a;
                load_lo_s = bus.b;
            end
        endcase
    end

    // Next-state decode and one-hot datapath strobes
    always_comb begin
        state_s    = state_r;
        accept_s   = 1'b0;
        load_s     = 1'b0;
        step_mul_s = 1'b0;
        step_div_s = 1'b0;
        negate_s   = 1'b0;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    accept_s = 1'b1;
                    if (short_s) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_RUN;
                        load_s  = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
`ifdef MDU_DIV_EN
                if (op_r == OP_UDIV) begin
                    step_div_s = 1'b1;
                end else begin
                    step_mul_s = 1'b1;
                end
`else
                step_mul_s = 1'b1;
`endif
                if (count_r == '0) begin
                    state_s = ST_FIX;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_FIX: begin
                negate_s = (op_r == OP_SMULL) && neg_r;
                state_s  = ST_DONE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, counter, handshake and result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            op_r     <= OP_MUL;
            neg_r    <= 1'b0;
            count_r  <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            dbz_r    <= 1'b0;
            res_lo_r <= '0;
            res_hi_r <= '0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == ST_RUN) || (state_s == ST_FIX);
            done_r  <= (state_s == ST_DONE);
            if (accept_s) begin
                op_r    <= bus.op;
                neg_r   <= (bus.op == OP_SMULL) && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                count_r <= CW'(WIDTH - 1);
            end else if (step_mul_s || step_div_s) begin
                count_r <= count_r - CW'(1);
            end else begin
                count_r <= count_r;
            end
            if (accept_s && short_s) begin
`ifdef MDU_DIV_EN
                res_lo_r <= '1;
                res_hi_r <= bus.a;
                dbz_r    <= 1'b1;
`else
                res_lo_r <= '0;
                res_hi_r <= '0;
                dbz_r    <= 1'b0;
`endif
            end else if (state_r == ST_FIX) begin
                res_lo_r <= fin_lo_s;
                res_hi_r <= fin_hi_s;
                dbz_r    <= 1'b0;
            end else begin
                dbz_r    <= 1'b0;
            end
        end
    end

    mdu_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .reset    (reset),
        .load     (load_s),
        .step_mul (step_mul_s),
        .step_div (step_div_s),
        .negate   (negate_s),
        .load_m   (load_m_s),
        .load_lo  (load_lo_s),
        .fin_hi   (fin_hi_s),
        .fin_lo   (fin_lo_s)
    );

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.div_by_zero = dbz_r;
    assign bus.result_lo   = res_lo_r;
    assign bus.result_hi   = res_hi_r;
    assign bus.stall       = busy_r | (bus.start & ((state_r == ST_IDLE) | (state_r == ST_DONE)));

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed vector bench for mdu_sequencer (WIDTH=32), with or without MDU_DIV_EN.
module tb_mdu_sequencer;
    import mdu_pkg::*;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dbz;
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_vec  = 0;
    int   n_miss = 0;
    vec_t vecs[12];

    always #5 clk = ~clk;

    mdu_sequencer_if #(.WIDTH(32)) bus ();

    mdu_sequencer #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Present a request in the current cycle; it is sampled at the next rising edge.
    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        #1;
        check("stall_on_start", 64'(bus.stall), 64'(1));
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        int gap;
        bit seen;
        gap  = 0;
        seen = 1'b0;
        lat  = 0;
        while (!seen && lat < 100) begin
            @(negedge clk);
            lat++;
            if (bus.done) seen = 1'b1;
            else if (!bus.stall) gap++;
        end
        check("stall_until_done", 64'(gap), 64'(0));
    endtask

    initial begin
        int lat;
        int extra;

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = 32'h0;
        bus.b     = 32'h0;

        vecs[0]  = '{OP_UMULL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 34};
        vecs[1]  = '{OP_SMULL, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0, 34};
        vecs[4]  = '{OP_MUL,   32'h00000006, 32'h00000007, 32'h0000002A, 32'h00000000, 1'b0, 34};
        vecs[5]  = '{OP_SMULL, 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, 1'b0, 34};
        vecs[6]  = '{OP_SMULL, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b0, 34};
        vecs[7]  = '{OP_UMULL, 32'h80000000, 32'h00000002, 32'h00000000, 32'h00000001, 1'b0, 34};
        vecs[10] = '{OP_MUL,   32'h00000000, 32'h00012345, 32'h00000000, 32'h00000000, 1'b0, 34};
        vecs[11] = '{OP_SMULL, 32'h00000000, 32'hFFFFFFF9, 32'h00000000, 32'h00000000, 1'b0, 34};
`ifdef MDU_DIV_EN
        vecs[2]  = '{OP_UDIV,  32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 34};
        vecs[3]  = '{OP_UDIV,  32'd100,      32'd0,        32'hFFFFFFFF, 32'd100,      1'b1, 1};
        vecs[8]  = '{OP_UDIV,  32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b0, 34};
        vecs[9]  = '{OP_UDIV,  32'd5,        32'd9,        32'd0,        32'd5,        1'b0, 34};
`else
        vecs[2]  = '{OP_UDIV,  32'd100,      32'd7,        32'd0,        32'd0,        1'b0, 1};
        vecs[3]  = '{OP_UDIV,  32'd100,      32'd0,        32'd0,        32'd0,        1'b0, 1};
        vecs[8]  = '{OP_UDIV,  32'hFFFFFFFF, 32'd1,        32'd0,        32'd0,        1'b0, 1};
        vecs[9]  = '{OP_UDIV,  32'd5,        32'd9,        32'd0,        32'd0,        1'b0, 1};
`endif

        repeat (2) @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_done", 64'(bus.done), 64'(0));
        check("rst_lo", 64'(bus.result_lo), 64'(0));
        check("rst_hi", 64'(bus.result_hi), 64'(0));
        check("rst_dbz", 64'(bus.div_by_zero), 64'(0));
        check("rst_stall", 64'(bus.stall), 64'(0));
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            launch(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(lat);
            check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
            check($sformatf("v%0d_lo", i), 64'(bus.result_lo), 64'(vecs[i].lo));
            check($sformatf("v%0d_hi", i), 64'(bus.result_hi), 64'(vecs[i].hi));
            check($sformatf("v%0d_dbz", i), 64'(bus.div_by_zero), 64'(vecs[i].dbz));
            check($sformatf("v%0d_busy_at_done", i), 64'(bus.busy), 64'(0));
            check($sformatf("v%0d_stall_at_done", i), 64'(bus.stall), 64'(0));
            @(negedge clk);
            check($sformatf("v%0d_done_pulse", i), 64'(bus.done), 64'(0));
            check($sformatf("v%0d_dbz_clear", i), 64'(bus.div_by_zero), 64'(0));
            check($sformatf("v%0d_lo_hold", i), 64'(bus.result_lo), 64'(vecs[i].lo));
        end

        // Back-to-back: new start presented in the done cycle
        launch(OP_UMULL, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(lat);
        check("b2b_first_lo", 64'(bus.result_lo), 64'(1));
        launch(OP_MUL, 32'd6, 32'd7);
        wait_done(lat);
        check("b2b_latency", 64'(lat), 64'(34));
        check("b2b_lo", 64'(bus.result_lo), 64'(42));
        check("b2b_hi", 64'(bus.result_hi), 64'(0));
        @(negedge clk);

        // Start pulsed mid-run with other operands must be ignored
        launch(OP_UMULL, 32'h10, 32'h10);
        repeat (5) @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_MUL;
        bus.a     = 32'd3;
        bus.b     = 32'd3;
        #1;
        check("run_start_stall", 64'(bus.stall), 64'(1));
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(lat);
        check("run_start_latency", 64'(lat), 64'(28));
        check("run_start_lo", 64'(bus.result_lo), 64'(32'h100));
        check("run_start_hi", 64'(bus.result_hi), 64'(0));
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) extra++;
        end
        check("run_start_extra_done", 64'(extra), 64'(0));
        check("run_start_lo_hold", 64'(bus.result_lo), 64'(32'h100));

        // Reset in the middle of a UMULL
        launch(OP_UMULL, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (9) @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_busy", 64'(bus.busy), 64'(0));
        check("midrst_done", 64'(bus.done), 64'(0));
        check("midrst_lo", 64'(bus.result_lo), 64'(0));
        check("midrst_hi", 64'(bus.result_hi), 64'(0));
        check("midrst_stall", 64'(bus.stall), 64'(0));
        reset = 1'b0;
        @(negedge clk);
        launch(OP_MUL, 32'd2, 32'd3);
        wait_done(lat);
        check("after_rst_latency", 64'(lat), 64'(34));
        check("after_rst_lo", 64'(bus.result_lo), 64'(6));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
